// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV64 control FSM: fetch/decode/execute/memory/writeback sequencing with ready handshake and timeout halt.
// Optional perf counters (cycle_cnt, retired_cnt) under `define MC_CTRL_PERF_EN.
module multicycle_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_code,
  input  logic             mem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             reg_we,
  output logic             alu_src_imm,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [1:0]       err_code
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_RALU = 7'b0110011;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       pc_we;
    logic       pc_sel;
    logic       reg_we;
    logic       alu_src_imm;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       halted;
  } ctrl_t;

  state_t          state, state_n;
  logic [6:0]      op_q, op_n;
  logic [WW-1:0]   wait_cnt, wait_n;
  logic [1:0]      err_q, err_n;
  ctrl_t           ctrl_q;
  logic            timeout;
  logic            sd_ack;
  logic            unused_inst;

  function automatic logic is_legal(input logic [6:0] op);
    return (op == OP_LD) || (op == OP_IALU) || (op == OP_SD) ||
           (op == OP_JALR) || (op == OP_RALU);
  endfunction

  // Moore strobes for the state being entered; registered so they switch cleanly on the edge.
  function automatic ctrl_t ctrl_of(input state_t s, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: c.imem_req = 1'b1;
      S_EXEC, S_MEM: begin
        c.alu_src_imm = (op != OP_RALU);
        c.alu_op      = (op == OP_IALU || op == OP_RALU) ? 2'b10 : 2'b00;
        if (s == S_MEM) begin
          c.dmem_req = 1'b1;
          c.dmem_we  = (op == OP_SD);
        end
      end
      S_WB: begin
        c.reg_we = 1'b1;
        c.pc_we  = 1'b1;
        c.pc_sel = (op == OP_JALR);
        c.wb_sel = (op == OP_JALR) ? 2'b10 : (op == OP_LD) ? 2'b01 : 2'b00;
      end
      S_HALT:  c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  // A ready on the last allowed cycle still completes the request.
  assign timeout = (MAX_WAIT != 0) && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_n = state;
    op_n    = op_q;
    wait_n  = wait_cnt;
    err_n   = err_q;
    case (state)
      S_IDLE: begin
        state_n = S_FETCH;
        wait_n  = '0;
      end
      S_FETCH, S_MEM: begin
        if (mem_ready) begin
          if (state == S_FETCH) begin
            state_n = S_DECODE;
          end else if (op_q == OP_SD) begin
            state_n = S_FETCH;
            wait_n  = '0;
          end else begin
            state_n = S_WB;
          end
        end else if (timeout) begin
          state_n = S_HALT;
          err_n   = 2'b10;
        end else begin
          wait_n = wait_cnt + 1'b1;
        end
      end
      S_DECODE: begin
        op_n = inst_code[6:0];
        if (is_legal(inst_code[6:0])) begin
          state_n = S_EXEC;
        end else begin
          state_n = S_HALT;
          err_n   = 2'b01;
        end
      end
      S_EXEC: begin
        if (op_q == OP_LD || op_q == OP_SD) begin
          state_n = S_MEM;
          wait_n  = '0;
        end else begin
          state_n = S_WB;
        end
      end
      S_WB: begin
        state_n = S_FETCH;
        wait_n  = '0;
      end
      S_HALT:  ;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      op_q     <= '0;
      wait_cnt <= '0;
      err_q    <= 2'b00;
      ctrl_q   <= '0;
    end else begin
      state    <= state_n;
      op_q     <= op_n;
      wait_cnt <= wait_n;
      err_q    <= err_n;
      ctrl_q   <= ctrl_of(state_n, op_n);
    end
  end

  // Handshake-qualified strobes fire only in the ready cycle, so they stay combinational on mem_ready.
  assign sd_ack      = (state == S_MEM) && (op_q == OP_SD) && mem_ready;
  assign ir_we       = (state == S_FETCH) && mem_ready;
  assign pc_we       = ctrl_q.pc_we | sd_ack;
  assign imem_req    = ctrl_q.imem_req;
  assign dmem_req    = ctrl_q.dmem_req;
  assign dmem_we     = ctrl_q.dmem_we;
  assign pc_sel      = ctrl_q.pc_sel;
  assign reg_we      = ctrl_q.reg_we;
  assign alu_src_imm = ctrl_q.alu_src_imm;
  assign alu_op      = ctrl_q.alu_op;
  assign wb_sel      = ctrl_q.wb_sel;
  assign halted      = ctrl_q.halted;
  assign err_code    = err_q;
  assign unused_inst = ^inst_code[31:7];

`ifdef MC_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      retired_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_HALT) cycle_cnt <= cycle_cnt + 1'b1;
      if (pc_we) retired_cnt <= retired_cnt + 1'b1;
    end
  end
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes per-cycle expected strobes, a negedge monitor pops and compares.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst_code = '0;
  logic        mem_ready = 1'b0;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_src_imm, halted;
  logic [1:0]  alu_op, wb_sel, err_code;
`ifdef MC_CTRL_PERF_EN
  logic [31:0] cycle_cnt, retired_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(16), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .inst_code(inst_code), .mem_ready(mem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .alu_src_imm(alu_src_imm),
    .alu_op(alu_op), .wb_sel(wb_sel), .halted(halted), .err_code(err_code)
`ifdef MC_CTRL_PERF_EN
    , .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
`endif
  );

  typedef struct packed {
    logic imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_src_imm;
    logic [1:0] alu_op, wb_sel;
    logic halted;
    logic [1:0] err_code;
  } obs_t;

  localparam obs_t Z      = '0;
  localparam obs_t FE     = '{imem_req:1'b1, default:'0};
  localparam obs_t FA     = '{imem_req:1'b1, ir_we:1'b1, default:'0};
  localparam obs_t EX_I   = '{alu_src_imm:1'b1, alu_op:2'b10, default:'0};
  localparam obs_t EX_R   = '{alu_op:2'b10, default:'0};
  localparam obs_t EX_M   = '{alu_src_imm:1'b1, default:'0};
  localparam obs_t MEM_LD = '{dmem_req:1'b1, alu_src_imm:1'b1, default:'0};
  localparam obs_t MEM_SD = '{dmem_req:1'b1, dmem_we:1'b1, alu_src_imm:1'b1, default:'0};
  localparam obs_t SD_ACK = '{dmem_req:1'b1, dmem_we:1'b1, alu_src_imm:1'b1, pc_we:1'b1, default:'0};
  localparam obs_t WB_ALU = '{reg_we:1'b1, pc_we:1'b1, default:'0};
  localparam obs_t WB_LD  = '{reg_we:1'b1, pc_we:1'b1, wb_sel:2'b01, default:'0};
  localparam obs_t WB_J   = '{reg_we:1'b1, pc_we:1'b1, pc_sel:1'b1, wb_sel:2'b10, default:'0};
  localparam obs_t H_ILL  = '{halted:1'b1, err_code:2'b01, default:'0};
  localparam obs_t H_TO   = '{halted:1'b1, err_code:2'b10, default:'0};

  localparam logic [31:0] ADDI = 32'h00500093;
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] LD   = 32'h00813083;
  localparam logic [31:0] SD   = 32'h00113423;
  localparam logic [31:0] JALR = 32'h000080E7;
  localparam logic [31:0] ILL  = 32'h0000007F;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  obs_t  act;

  assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, reg_we, alu_src_imm,
                alu_op, wb_sel, halted, err_code};

  always @(negedge clk) begin : monitor
    obs_t  e;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, e, $time);
      end
    end
  end

  // One call = one clock cycle: drive inputs just after the edge and queue that cycle's expected strobes.
  task automatic cyc(input logic r, input logic rdy, input logic [31:0] ins,
                     input obs_t e, input string nm);
    @(posedge clk);
    #1;
    rst_n     = r;
    mem_ready = rdy;
    inst_code = ins;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    cyc(0, 0, 0, Z, "reset");
    cyc(0, 1, 0, Z, "reset_ready");
    cyc(1, 1, ADDI, Z, "idle");
    // ADDI, zero-wait memory: 4 cycles
    cyc(1, 1, ADDI, FA,     "addi_fetch");
    cyc(1, 1, ADDI, Z,      "addi_decode");
    cyc(1, 1, ADDI, EX_I,   "addi_exec");
    cyc(1, 1, ADDI, WB_ALU, "addi_wb");
    // R-type ADD
    cyc(1, 1, ADD, FA,     "add_fetch");
    cyc(1, 1, ADD, Z,      "add_decode");
    cyc(1, 1, ADD, EX_R,   "add_exec");
    cyc(1, 1, ADD, WB_ALU, "add_wb");
    // LD with 3 wait cycles on dmem: 8 cycles total
    cyc(1, 1, LD, FA,     "ld_fetch");
    cyc(1, 0, LD, Z,      "ld_decode");
    cyc(1, 0, LD, EX_M,   "ld_exec");
    cyc(1, 0, LD, MEM_LD, "ld_mem_w0");
    cyc(1, 0, LD, MEM_LD, "ld_mem_w1");
    cyc(1, 0, LD, MEM_LD, "ld_mem_w2");
    cyc(1, 1, LD, MEM_LD, "ld_mem_ack");
    cyc(1, 0, LD, WB_LD,  "ld_wb");
    // SD: one wait cycle, pc_we only on the ready cycle
    cyc(1, 1, SD, FA,     "sd_fetch");
    cyc(1, 0, SD, Z,      "sd_decode");
    cyc(1, 0, SD, EX_M,   "sd_exec");
    cyc(1, 0, SD, MEM_SD, "sd_mem_wait");
    cyc(1, 1, SD, SD_ACK, "sd_mem_ack");
    // JALR
    cyc(1, 1, JALR, FA,   "jalr_fetch");
    cyc(1, 1, JALR, Z,    "jalr_decode");
    cyc(1, 1, JALR, EX_M, "jalr_exec");
    cyc(1, 1, JALR, WB_J, "jalr_wb");
    // ready on the 16th fetch cycle (wait_cnt == 15) beats the timeout
    for (int i = 0; i < 15; i++) cyc(1, 0, ILL, FE, "fetch_wait");
    cyc(1, 1, ILL, FA, "fetch_last_ready");
    // illegal opcode
    cyc(1, 0, ILL, Z,     "ill_decode");
    cyc(1, 1, ILL, H_ILL, "ill_halt0");
    cyc(1, 1, ILL, H_ILL, "ill_halt1");
    cyc(1, 0, ILL, H_ILL, "ill_halt2");
    // reset clears error, then reset mid-MEM of a LD
    cyc(0, 0, LD, Z,      "reset2");
    cyc(1, 1, LD, Z,      "idle2");
    cyc(1, 1, LD, FA,     "ld2_fetch");
    cyc(1, 0, LD, Z,      "ld2_decode");
    cyc(1, 0, LD, EX_M,   "ld2_exec");
    cyc(1, 0, LD, MEM_LD, "ld2_mem");
    cyc(0, 1, LD, Z,      "mid_mem_reset");
    cyc(1, 1, LD, Z,      "idle3");
    cyc(1, 0, LD, FE,     "fetch_after_reset");
    // fetch timeout: 16 unacknowledged cycles in total, then HALT
    for (int i = 0; i < 15; i++) cyc(1, 0, 0, FE, "fetch_stall");
    cyc(1, 0, 0, H_TO, "timeout_halt0");
    cyc(1, 1, 0, H_TO, "timeout_halt_ready");
    cyc(1, 0, 0, H_TO, "timeout_halt2");

    begin : drain
      for (int i = 0; i < 8; i++) begin
        if (exp_q.size() == 0) break;
        @(posedge clk);
      end
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
